// File: rtl/ysyx_041461_pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// FSM encodings, arbitration causes and the stage-control bundle.
package ysyx_041461_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTL_RUN    = 2'd0,
    PCTL_DRAIN  = 2'd1,
    PCTL_FLUSH  = 2'd2,
    PCTL_RESUME = 2'd3
  } pctl_state_e;

  typedef enum logic [2:0] {
    CS_NONE,
    CS_TRAP,
    CS_MEM,
    CS_EXE,
    CS_BR,
    CS_LU,
    CS_IF,
    CS_FENCEI
  } stall_cause_e;

  typedef struct packed {
    logic if_en;
    logic id_en;
    logic exe_en;
    logic mem_en;
    logic wb_en;
    logic id_bub;
    logic exe_bub;
    logic mem_bub;
    logic wb_bub;
  } pctl_ctl_t;

  function automatic pctl_ctl_t ctl_run();
    pctl_ctl_t c;
    c = '0;
    c.if_en  = 1'b1;
    c.id_en  = 1'b1;
    c.exe_en = 1'b1;
    c.mem_en = 1'b1;
    c.wb_en  = 1'b1;
    return c;
  endfunction

  function automatic pctl_ctl_t ctl_squash();
    pctl_ctl_t c;
    c = ctl_run();
    c.id_bub  = 1'b1;
    c.exe_bub = 1'b1;
    c.mem_bub = 1'b1;
    c.wb_bub  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ysyx_041461_pipe_ctrl_if.sv
// Stage status in, stage enables/bubbles/redirect out.
// master = datapath side, slave = controller side.
interface ysyx_041461_pipe_ctrl_if #(
  parameter int PC_W = 64
);
  logic            if_busy;
  logic            exe_busy;
  logic            mem_busy;
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_is_fencei;
  logic            exe_valid;
  logic            exe_is_load;
  logic [4:0]      exe_rd;
  logic            mem_valid;
  logic            wb_valid;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            trap_req;
  logic [PC_W-1:0] trap_target;
  logic            icache_flush_ack;
  logic            if_en;
  logic            id_en;
  logic            exe_en;
  logic            mem_en;
  logic            wb_en;
  logic            id_bubble;
  logic            exe_bubble;
  logic            mem_bubble;
  logic            wb_bubble;
  logic            pc_redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            icache_flush_req;
  logic            flush_err;

  modport master (
    output if_busy, exe_busy, mem_busy,
    output id_valid, id_rs1, id_rs2, id_is_fencei,
    output exe_valid, exe_is_load, exe_rd,
    output mem_valid, wb_valid,
    output br_taken, br_target,
    output trap_req, trap_target,
    output icache_flush_ack,
    input  if_en, id_en, exe_en, mem_en, wb_en,
    input  id_bubble, exe_bubble, mem_bubble, wb_bubble,
    input  pc_redirect, redirect_pc,
    input  icache_flush_req, flush_err
  );

  modport slave (
    input  if_busy, exe_busy, mem_busy,
    input  id_valid, id_rs1, id_rs2, id_is_fencei,
    input  exe_valid, exe_is_load, exe_rd,
    input  mem_valid, wb_valid,
    input  br_taken, br_target,
    input  trap_req, trap_target,
    input  icache_flush_ack,
    output if_en, id_en, exe_en, mem_en, wb_en,
    output id_bubble, exe_bubble, mem_bubble, wb_bubble,
    output pc_redirect, redirect_pc,
    output icache_flush_req, flush_err
  );
endinterface

// File: rtl/ysyx_041461_hazard_detect.sv
// Load-use compare between ID sources and an in-flight load in EXE.
// Kept standalone so the forwarding unit can share it.
module ysyx_041461_hazard_detect (
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_exe_valid,
  input  logic       i_exe_is_load,
  input  logic [4:0] i_exe_rd,
  output logic       o_lu
);
  logic w_hit;

  assign w_hit = (i_exe_rd == i_id_rs1) | (i_exe_rd == i_id_rs2);
  assign o_lu  = i_id_valid & i_exe_valid & i_exe_is_load
               & (i_exe_rd != 5'd0) & w_hit;
endmodule

// File: rtl/ysyx_041461_pipe_ctrl.sv
// Pipeline hazard/redirect controller with fence.i drain-flush sequencing.
// Define YSYX_041461_PERF_CNT_EN to add stall/redirect perf counters.
module ysyx_041461_pipe_ctrl
  import ysyx_041461_pipe_ctrl_pkg::*;
#(
  parameter int PC_W      = 64,
  parameter int FLUSH_TMO = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_041461_pipe_ctrl_if.slave   io
`ifdef YSYX_041461_PERF_CNT_EN
  ,
  output logic [63:0]              o_perf_lu_cnt,
  output logic [63:0]              o_perf_mem_stall_cnt,
  output logic [63:0]              o_perf_exe_stall_cnt,
  output logic [63:0]              o_perf_flush_cnt
`endif
);
  localparam int CW = $clog2(FLUSH_TMO + 1);

  pctl_state_e  r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic         r_flush_err, w_err_set;
  logic         w_lu;
  logic         w_pipe_empty;
  stall_cause_e w_cause;
  pctl_ctl_t    w_ctl;
  logic         w_redir;
  logic [PC_W-1:0] w_rpc;

  ysyx_041461_hazard_detect u_hzd (
    .i_id_valid    (io.id_valid),
    .i_id_rs1      (io.id_rs1),
    .i_id_rs2      (io.id_rs2),
    .i_exe_valid   (io.exe_valid),
    .i_exe_is_load (io.exe_is_load),
    .i_exe_rd      (io.exe_rd),
    .o_lu          (w_lu)
  );

  assign w_pipe_empty = ~(io.exe_valid | io.mem_valid | io.wb_valid);

  always_comb begin
    w_cause = CS_NONE;
    priority case (1'b1)
      io.trap_req:                   w_cause = CS_TRAP;
      io.mem_busy:                   w_cause = CS_MEM;
      io.exe_busy:                   w_cause = CS_EXE;
      io.br_taken:                   w_cause = CS_BR;
      w_lu:                          w_cause = CS_LU;
      io.if_busy:                    w_cause = CS_IF;
      io.id_is_fencei & io.id_valid: w_cause = CS_FENCEI;
      default:                       w_cause = CS_NONE;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_ctl     = ctl_run();
    w_redir   = 1'b0;
    w_rpc     = '0;
    w_cnt_nxt = '0;
    w_err_set = 1'b0;
    unique case (r_state)
      PCTL_RUN: begin
        unique case (w_cause)
          CS_TRAP: begin
            w_ctl   = ctl_squash();
            w_redir = 1'b1;
            w_rpc   = io.trap_target;
          end
          CS_MEM: begin
            w_ctl.if_en  = 1'b0;
            w_ctl.id_en  = 1'b0;
            w_ctl.exe_en = 1'b0;
            w_ctl.mem_en = 1'b0;
            w_ctl.wb_bub = 1'b1;
          end
          CS_EXE: begin
            w_ctl.if_en   = 1'b0;
            w_ctl.id_en   = 1'b0;
            w_ctl.exe_en  = 1'b0;
            w_ctl.mem_bub = 1'b1;
          end
          CS_BR: begin
            w_ctl.id_bub  = 1'b1;
            w_ctl.exe_bub = 1'b1;
            w_redir       = 1'b1;
            w_rpc         = io.br_target;
          end
          CS_LU: begin
            w_ctl.if_en   = 1'b0;
            w_ctl.id_en   = 1'b0;
            w_ctl.exe_bub = 1'b1;
          end
          CS_IF: begin
            w_ctl.if_en  = 1'b0;
            w_ctl.id_bub = 1'b1;
          end
          CS_FENCEI: begin
            w_ctl.if_en   = 1'b0;
            w_ctl.id_en   = 1'b0;
            w_ctl.exe_bub = 1'b1;
            w_next        = PCTL_DRAIN;
          end
          default: ;
        endcase
      end
      PCTL_DRAIN: begin
        w_ctl.if_en   = 1'b0;
        w_ctl.id_en   = 1'b0;
        w_ctl.exe_bub = 1'b1;
        if (io.trap_req) begin
          w_ctl   = ctl_squash();
          w_redir = 1'b1;
          w_rpc   = io.trap_target;
          w_next  = PCTL_RUN;
        end else begin
          if (io.mem_busy) begin
            w_ctl.exe_en = 1'b0;
            w_ctl.mem_en = 1'b0;
            w_ctl.wb_bub = 1'b1;
          end else if (io.exe_busy) begin
            w_ctl.exe_en  = 1'b0;
            w_ctl.mem_bub = 1'b1;
          end
          if (w_pipe_empty) w_next = PCTL_FLUSH;
        end
      end
      PCTL_FLUSH: begin
        w_ctl.if_en   = 1'b0;
        w_ctl.id_en   = 1'b0;
        w_ctl.exe_bub = 1'b1;
        if (io.icache_flush_ack) begin
          w_next = PCTL_RESUME;
        end else if (r_cnt == CW'(FLUSH_TMO - 1)) begin
          w_err_set = 1'b1;
          w_next    = PCTL_RESUME;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PCTL_RESUME: begin
        w_next = PCTL_RUN;
        if (io.trap_req) begin
          w_ctl   = ctl_squash();
          w_redir = 1'b1;
          w_rpc   = io.trap_target;
        end else begin
          // br_target carries the fence.i PC+4 here
          w_ctl.id_bub = 1'b1;
          w_redir      = 1'b1;
          w_rpc        = io.br_target;
        end
      end
      default: w_next = PCTL_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PCTL_RUN;
      r_cnt       <= '0;
      r_flush_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) r_flush_err <= 1'b1;
    end
  end

  assign io.if_en            = w_ctl.if_en;
  assign io.id_en            = w_ctl.id_en;
  assign io.exe_en           = w_ctl.exe_en;
  assign io.mem_en           = w_ctl.mem_en;
  assign io.wb_en            = w_ctl.wb_en;
  assign io.id_bubble        = w_ctl.id_bub;
  assign io.exe_bubble       = w_ctl.exe_bub;
  assign io.mem_bubble       = w_ctl.mem_bub;
  assign io.wb_bubble        = w_ctl.wb_bub;
  assign io.pc_redirect      = w_redir;
  assign io.redirect_pc      = w_rpc;
  assign io.icache_flush_req = (r_state == PCTL_FLUSH);
  assign io.flush_err        = r_flush_err;

  // WB is empty during FLUSH, so no trap can be raised there
  a_no_trap_in_flush: assert property (
    @(posedge clk) disable iff (rst)
    !((r_state == PCTL_FLUSH) && io.trap_req)
  );

`ifdef YSYX_041461_PERF_CNT_EN
  logic [63:0] r_pc_lu, r_pc_mem, r_pc_exe, r_pc_fl;
  logic        w_in_run, w_fl_inc;

  assign w_in_run = (r_state == PCTL_RUN);
  assign w_fl_inc = w_redir & (io.trap_req | w_in_run);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_lu  <= '0;
      r_pc_mem <= '0;
      r_pc_exe <= '0;
      r_pc_fl  <= '0;
    end else begin
      if (w_in_run && w_cause == CS_LU && r_pc_lu != '1)
        r_pc_lu <= r_pc_lu + 64'd1;
      if (w_in_run && w_cause == CS_MEM && r_pc_mem != '1)
        r_pc_mem <= r_pc_mem + 64'd1;
      if (w_in_run && w_cause == CS_EXE && r_pc_exe != '1)
        r_pc_exe <= r_pc_exe + 64'd1;
      if (w_fl_inc && r_pc_fl != '1)
        r_pc_fl <= r_pc_fl + 64'd1;
    end
  end

  assign o_perf_lu_cnt        = r_pc_lu;
  assign o_perf_mem_stall_cnt = r_pc_mem;
  assign o_perf_exe_stall_cnt = r_pc_exe;
  assign o_perf_flush_cnt     = r_pc_fl;
`endif

endmodule
